// File: rtl/lfsr_param.sv
// Parametrised Fibonacci LFSR with run-time seed load, all-zero recovery and a period-wrap pulse.
// Define LFSR_STEP_COUNT_EN to build the step counter; otherwise step_cnt is tied to zero.
module lfsr_param #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'h60,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] step_cnt
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;
    logic             r_wrap;
    logic             r_lockup;
    logic             w_fb;
    logic             w_seedZero;
    logic             w_stateZero;
    logic [WIDTH-1:0] w_stepState;
    logic             w_stepWrap;

    assign w_fb        = ^(r_state & TAPS);
    assign w_seedZero  = (seed_in == '0);
    assign w_stateZero = (r_state == '0);

    // A zero state can only appear with non-maximal taps; stepping out of it restarts at SEED.
    assign w_stepState = w_stateZero ? SEED : {r_state[WIDTH-2:0], w_fb};
    assign w_stepWrap  = (w_stepState == r_ref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= SEED;
            r_ref    <= SEED;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
            if (w_seedZero) begin
                r_state  <= SEED;
                r_ref    <= SEED;
                r_lockup <= 1'b1;
            end else begin
                r_state  <= seed_in;
                r_ref    <= seed_in;
                r_lockup <= 1'b0;
            end
        end else if (en) begin
            r_state <= w_stepState;
            r_wrap  <= w_stepWrap;
            if (w_stateZero) begin
                r_lockup <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

`ifdef LFSR_STEP_COUNT_EN
    logic [WIDTH-1:0] r_stepCnt;

    // The counter restarts on the same step that raises wrap, so it spans one full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stepCnt <= '0;
        end else if (load) begin
            r_stepCnt <= '0;
        end else if (en) begin
            if (w_stepWrap) begin
                r_stepCnt <= '0;
            end else begin
                r_stepCnt <= r_stepCnt + 1'b1;
            end
        end
    end

    assign step_cnt = r_stepCnt;
`else
    assign step_cnt = '0;
`endif

    assign data_out = r_state;
    assign bit_out  = r_state[WIDTH-1];
    assign wrap     = r_wrap;
    assign lockup   = r_lockup;

endmodule

// File: tb/tb_lfsr_param.sv
// Self-checking bench for lfsr_param at default parameters (WIDTH=7, TAPS=7'h60, SEED=1).
// A behavioural model pushes expected outputs into a scoreboard that each test pops and compares.
module tb_lfsr_param;

    localparam int W = 7;
    localparam logic [W-1:0] MTAPS = 7'h60;
    localparam logic [W-1:0] MSEED = 7'h01;

    typedef struct {
        logic [W-1:0] data;
        logic         wrap;
        logic         lock;
        logic [W-1:0] cnt;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] seed_in;
    logic [W-1:0] data_out;
    logic         bit_out;
    logic         wrap;
    logic         lockup;
    logic [W-1:0] step_cnt;

    int errors;
    int checks;

    exp_t sb[$];

    logic [W-1:0] m_state;
    logic [W-1:0] m_ref;
    logic         m_wrap;
    logic         m_lock;
    logic [W-1:0] m_cnt;

    lfsr_param dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .seed_in (seed_in),
        .data_out(data_out),
        .bit_out (bit_out),
        .wrap    (wrap),
        .lockup  (lockup),
        .step_cnt(step_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_state = MSEED;
        m_ref   = MSEED;
        m_wrap  = 1'b0;
        m_lock  = 1'b0;
        m_cnt   = '0;
    endtask

    // Behavioural reference: feedback computed bit by bit from the tap mask.
    task automatic modelApply(input logic e, input logic l, input logic [W-1:0] s);
        logic fb;
        if (l) begin
            if (s != '0) begin
                m_state = s;
                m_ref   = s;
                m_lock  = 1'b0;
            end else begin
                m_state = MSEED;
                m_ref   = MSEED;
                m_lock  = 1'b1;
            end
            m_wrap = 1'b0;
            m_cnt  = '0;
        end else if (e) begin
            if (m_state == '0) begin
                m_state = MSEED;
                m_lock  = 1'b1;
            end else begin
                fb = 1'b0;
                for (int i = 0; i < W; i++) begin
                    if (MTAPS[i]) fb = fb ^ m_state[i];
                end
                m_state = {m_state[W-2:0], fb};
            end
            m_wrap = (m_state == m_ref);
            m_cnt  = m_wrap ? '0 : m_cnt + 1'b1;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    // Drives one cycle of stimulus, queues the expected outcome and returns #1 after the edge.
    task automatic driveCycle(input logic e, input logic l, input logic [W-1:0] s);
        exp_t x;
        en      = e;
        load    = l;
        seed_in = s;
        modelApply(e, l, s);
        x.data = m_state;
        x.wrap = m_wrap;
        x.lock = m_lock;
`ifdef LFSR_STEP_COUNT_EN
        x.cnt  = m_cnt;
`else
        x.cnt  = '0;
`endif
        sb.push_back(x);
        @(posedge clk);
        #1;
        en   = 1'b0;
        load = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        exp_t e;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 7'h01 || bit_out !== 1'b0 || wrap !== 1'b0 || lockup !== 1'b0 || step_cnt !== 7'h00) begin
            errors++;
            $display("[TB] FAIL reset_async: data=%h bit=%b wrap=%b lock=%b cnt=%0d, expected 01 0 0 0 0",
                     data_out, bit_out, wrap, lockup, step_cnt);
        end
        #2;
        rst = 1'b0;
        modelReset();
        driveCycle(1'b0, 1'b0, '0);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || bit_out !== e.data[W-1]) begin
            errors++;
            $display("[TB] FAIL reset_hold: data=%h wrap=%b lock=%b cnt=%0d bit=%b, expected data=%h wrap=%b lock=%b cnt=%0d",
                     data_out, wrap, lockup, step_cnt, bit_out, e.data, e.wrap, e.lock, e.cnt);
        end
    endtask

    task automatic test_sequence();
        exp_t e;
        logic [W-1:0] seq [7];
        seq = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
        for (int i = 0; i < 7; i++) begin
            driveCycle(1'b1, 1'b0, '0);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || bit_out !== e.data[W-1]) begin
                errors++;
                $display("[TB] FAIL seq_step%0d: data=%h wrap=%b lock=%b cnt=%0d bit=%b, expected data=%h wrap=%b lock=%b cnt=%0d",
                         i, data_out, wrap, lockup, step_cnt, bit_out, e.data, e.wrap, e.lock, e.cnt);
            end
            checks++;
            if (data_out !== seq[i]) begin
                errors++;
                $display("[TB] FAIL seq_table%0d: data=%h, expected %h", i, data_out, seq[i]);
            end
        end
    endtask

    task automatic test_full_period();
        exp_t e;
        int   wraps;
        int   wrapStep;
        int   dupes;
        bit   seen [128];
        pulseReset();
        wraps    = 0;
        wrapStep = -1;
        dupes    = 0;
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 127; i++) begin
            driveCycle(1'b1, 1'b0, '0);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || bit_out !== e.data[W-1]) begin
                errors++;
                $display("[TB] FAIL period_step%0d: data=%h wrap=%b lock=%b cnt=%0d bit=%b, expected data=%h wrap=%b lock=%b cnt=%0d",
                         i, data_out, wrap, lockup, step_cnt, bit_out, e.data, e.wrap, e.lock, e.cnt);
            end
            if (wrap === 1'b1) begin
                wraps++;
                wrapStep = i;
            end
            if (seen[data_out]) dupes++;
            seen[data_out] = 1'b1;
        end
        checks++;
        if (wraps != 1 || wrapStep != 127 || data_out !== 7'h01) begin
            errors++;
            $display("[TB] FAIL period_wrap: wraps=%0d at step %0d data=%h, expected 1 at step 127 data=01",
                     wraps, wrapStep, data_out);
        end
        checks++;
        if (dupes != 0 || seen[0]) begin
            errors++;
            $display("[TB] FAIL period_visit: duplicates=%0d zero_seen=%b, expected 0 and 0", dupes, seen[0]);
        end
        driveCycle(1'b1, 1'b0, '0);
        e = sb.pop_front();
        checks++;
        if (wrap !== 1'b0 || data_out !== e.data) begin
            errors++;
            $display("[TB] FAIL period_after: wrap=%b data=%h, expected wrap=0 data=%h", wrap, data_out, e.data);
        end
    endtask

    task automatic test_load_seed();
        exp_t e;
        int   wraps;
        int   wrapStep;
        driveCycle(1'b1, 1'b1, 7'h55);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || data_out !== 7'h55) begin
            errors++;
            $display("[TB] FAIL load_55: data=%h wrap=%b lock=%b cnt=%0d, expected data=55 wrap=%b lock=%b cnt=%0d",
                     data_out, wrap, lockup, step_cnt, e.wrap, e.lock, e.cnt);
        end
        wraps    = 0;
        wrapStep = -1;
        for (int i = 1; i <= 127; i++) begin
            driveCycle(1'b1, 1'b0, '0);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || bit_out !== e.data[W-1]) begin
                errors++;
                $display("[TB] FAIL load_step%0d: data=%h wrap=%b lock=%b cnt=%0d bit=%b, expected data=%h wrap=%b lock=%b cnt=%0d",
                         i, data_out, wrap, lockup, step_cnt, bit_out, e.data, e.wrap, e.lock, e.cnt);
            end
            if (wrap === 1'b1) begin
                wraps++;
                wrapStep = i;
            end
        end
        checks++;
        if (wraps != 1 || wrapStep != 127 || data_out !== 7'h55) begin
            errors++;
            $display("[TB] FAIL load_wrap: wraps=%0d at step %0d data=%h, expected 1 at step 127 data=55",
                     wraps, wrapStep, data_out);
        end
    endtask

    task automatic test_lockup();
        exp_t e;
        driveCycle(1'b0, 1'b1, 7'h00);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.data || lockup !== 1'b1 || wrap !== e.wrap || step_cnt !== e.cnt || data_out !== 7'h01) begin
            errors++;
            $display("[TB] FAIL lock_zero_load: data=%h lock=%b wrap=%b cnt=%0d, expected data=01 lock=1 wrap=%b cnt=%0d",
                     data_out, lockup, wrap, step_cnt, e.wrap, e.cnt);
        end
        for (int i = 0; i < 10; i++) begin
            driveCycle(1'b1, 1'b0, '0);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || lockup !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lock_sticky%0d: data=%h wrap=%b lock=%b cnt=%0d, expected data=%h wrap=%b lock=1 cnt=%0d",
                         i, data_out, wrap, lockup, step_cnt, e.data, e.wrap, e.cnt);
            end
        end
        driveCycle(1'b0, 1'b1, 7'h12);
        e = sb.pop_front();
        checks++;
        if (data_out !== 7'h12 || lockup !== 1'b0 || wrap !== e.wrap || step_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL lock_clear: data=%h lock=%b wrap=%b cnt=%0d, expected data=12 lock=0 wrap=%b cnt=%0d",
                     data_out, lockup, wrap, step_cnt, e.wrap, e.cnt);
        end
    endtask

    task automatic test_en_toggle();
        exp_t e;
        logic pattern [4];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            driveCycle(pattern[i], 1'b0, '0);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.data || wrap !== 1'b0 || lockup !== e.lock || step_cnt !== e.cnt || bit_out !== e.data[W-1]) begin
                errors++;
                $display("[TB] FAIL toggle%0d: data=%h wrap=%b lock=%b cnt=%0d bit=%b, expected data=%h wrap=0 lock=%b cnt=%0d",
                         i, data_out, wrap, lockup, step_cnt, bit_out, e.data, e.lock, e.cnt);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 7'h01 || bit_out !== 1'b0 || wrap !== 1'b0 || lockup !== 1'b0 || step_cnt !== 7'h00) begin
            errors++;
            $display("[TB] FAIL reset_midrun: data=%h bit=%b wrap=%b lock=%b cnt=%0d, expected 01 0 0 0 0",
                     data_out, bit_out, wrap, lockup, step_cnt);
        end
        #1;
        rst = 1'b0;
        modelReset();
        driveCycle(1'b1, 1'b0, '0);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.data || wrap !== e.wrap || lockup !== e.lock || step_cnt !== e.cnt || data_out !== 7'h02) begin
            errors++;
            $display("[TB] FAIL reset_resume: data=%h wrap=%b lock=%b cnt=%0d, expected data=02 wrap=%b lock=%b cnt=%0d",
                     data_out, wrap, lockup, step_cnt, e.wrap, e.lock, e.cnt);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        seed_in = '0;
        modelReset();
        test_reset();
        test_sequence();
        test_full_period();
        test_load_seed();
        test_lockup();
        test_en_toggle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
